// File: rtl/console_tx.sv
// Console character output: 16-bit bus writes feed a small FIFO drained onto a UART line (8N1, LSB first).
// Optional even-parity bit between data and stop when CONSOLE_TX_PARITY_EN is defined (8E1).
module console_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_en,
    input  logic [15:0] in,
    input  logic        out_en,
    output logic [15:0] out,
    output logic        tx,
    output logic        done
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef CONSOLE_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;
    state_t             r_state;
    logic [2:0]         r_bit;
    logic [15:0]        r_baud;
    logic [7:0]         r_shift;
`ifdef CONSOLE_TX_PARITY_EN
    logic               r_par;
`endif

    logic w_full, w_empty, w_busy, w_push, w_pop, w_baud_end, w_unused;

    assign w_full     = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_push     = in_en && !w_full;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;
    assign w_baud_end = (r_baud == 16'(CLKS_PER_BIT - 1));
    assign w_unused   = ^in[15:8];

    // Storage needs no reset: reset clears the pointers and count, which is enough.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= in[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            out        <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
            if (in_en && w_full) r_overflow <= 1'b1;
            if (out_en) out <= {12'b0, r_overflow, w_busy, w_empty, w_full};
        end
    end

    // Line FSM: tx is loaded on the same edge that enters each bit state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bit   <= '0;
            r_baud  <= '0;
            r_shift <= '0;
            tx      <= 1'b1;
            done    <= 1'b0;
`ifdef CONSOLE_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
`ifdef CONSOLE_TX_PARITY_EN
                        r_par   <= ^r_mem[r_rptr];
`endif
                        r_baud  <= '0;
                        r_state <= ST_START;
                        tx      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                        tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit == 3'd7) begin
`ifdef CONSOLE_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            tx      <= r_par;
`else
                            r_state <= ST_STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef CONSOLE_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= ST_STOP;
                        tx      <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= ST_IDLE;
                        done    <= 1'b1;
                        tx      <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    tx      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_console_tx.sv
// Directed bench for console_tx: a line monitor captures frames, the main thread checks them.
module tb_console_tx;
  localparam int CPB = 4;
`ifdef CONSOLE_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_en = 1'b0;
  logic [15:0] din = '0;
  logic        out_en = 1'b0;
  logic [15:0] dout;
  logic        tx, done;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [10:0] bits;
    logic        stable;
    logic        dn_in;
    logic        dn_end;
    int          gap;
  } frm_t;
  frm_t q[$];

  console_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in(din), .out_en(out_en),
    .out(dout), .tx(tx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] b);
    din = {8'hA5, b}; in_en = 1'b1; tick(); in_en = 1'b0;
  endtask

  task automatic rd(output logic [15:0] v);
    out_en = 1'b1; tick(); out_en = 1'b0; v = dout;
  endtask

  task automatic wait_q(input int n, input string tag);
    int t = 0;
    while (q.size() < n && t < 3000) begin tick(); t++; end
    chk(tag, q.size(), n);
  endtask

  // Expected line bits, start bit at index 0, stop bit at the top.
  function automatic logic [10:0] expw(input logic [7:0] b);
`ifdef CONSOLE_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  task automatic chkf(input string tag, input int idx, input logic [7:0] b);
    if (idx >= q.size()) chk({tag, "_missing"}, 1, 0);
    else chk(tag, {q[idx].bits, q[idx].stable, q[idx].dn_in, q[idx].dn_end},
             {expw(b), 3'b101});
  endtask

  // Line monitor: samples mid-cycle, one frame per falling edge; frames cut by rst are dropped.
  initial begin
    int idle;
    frm_t f;
    logic [3:0] v;
    logic ab;
    idle = 0;
    forever begin
      @(posedge clk); #3;
      if (rst || tx) idle++;
      else begin
        f.bits = '0; f.stable = 1'b1; f.dn_in = 1'b0; f.gap = idle; ab = 1'b0;
        for (int k = 0; k < NB; k++) begin
          v = '0;
          for (int c = 0; c < CPB; c++) begin
            if (k != 0 || c != 0) begin @(posedge clk); #3; end
            v[c] = tx; f.dn_in |= done; ab |= rst;
          end
          f.bits[k] = v[0];
          if (v != {4{v[0]}}) f.stable = 1'b0;
        end
        @(posedge clk); #3;
        f.dn_end = done; ab |= rst;
        idle = 1;
        if (!ab) q.push_back(f);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] st;
    logic        acc;

    // 1: reset and idle
    tick(); tick(); rst = 1'b0;
    chk("rst_out", dout, 16'h0000);
    chk("rst_tx", tx, 1'b1);
    chk("rst_done", done, 1'b0);
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); acc |= (~tx) | done; end
    chk("idle_quiet", acc, 1'b0);
    rd(st);
    chk("idle_status", st, 16'h0002);

    // 2: single byte, latency and line shape
    wr(8'h55);
    chk("lat_after_wr", tx, 1'b1);
    tick();
    chk("lat_fall", tx, 1'b0);
    wait_q(1, "t2_count");
    chkf("t2_frame55", 0, 8'h55);
`ifndef CONSOLE_TX_PARITY_EN
    if (q.size() > 0) chk("t2_const", q[0].bits, 11'h2AA);
`endif

    // 3: four back-to-back writes
    q.delete();
    for (int i = 1; i <= 4; i++) wr(8'(i));
    rd(st);
    chk("t3_status", st, 16'h0004);
    wait_q(4, "t3_count");
    for (int i = 0; i < 4; i++) chkf("t3_frame", i, 8'(i + 1));
    for (int i = 1; i < 4; i++)
      if (i < q.size()) chk("t3_gap", q[i].gap, 1);

    // 4: overflow
    q.delete();
    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    rd(st);
    chk("t4_status_full", st, 16'h000D);
    wait_q(5, "t4_count");
    for (int i = 0; i < 5; i++) chkf("t4_frame", i, 8'h10 + 8'(i));
    for (int i = 0; i < 150; i++) tick();
    chk("t4_no_sixth", q.size(), 5);
    rd(st);
    chk("t4_sticky", st, 16'h000A);

    // 5: reset mid-frame
    rst = 1'b1; tick(); rst = 1'b0;
    rd(st);
    chk("t5_ovf_cleared", st, 16'h0002);
    q.delete();
    wr(8'hFF); wr(8'h21); wr(8'h22);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1; tick();
    chk("t5_tx_high", tx, 1'b1);
    chk("t5_done_low", done, 1'b0);
    rst = 1'b0;
    rd(st);
    chk("t5_status", st, 16'h0002);
    acc = 1'b0;
    for (int i = 0; i < 200; i++) begin tick(); acc |= ~tx; end
    chk("t5_line_quiet", acc, 1'b0);
    chk("t5_no_frames", q.size(), 0);

`ifdef CONSOLE_TX_PARITY_EN
    // 6: parity bit
    q.delete();
    wr(8'h07);
    wait_q(1, "t6_count7");
    if (q.size() > 0) chk("t6_par07", q[0].bits, 11'h60E);
    chkf("t6_frame07", 0, 8'h07);
    wr(8'h03);
    wait_q(2, "t6_count3");
    if (q.size() > 1) chk("t6_par03", q[1].bits, 11'h406);
    chkf("t6_frame03", 1, 8'h03);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
